battle_engine: RTL
==================

# battle_engine

Parametrised turn-based battle resolver. On `start` it initialises both fighters, then alternates player and enemy turns through a valid/ready action channel. Each action is resolved with an internal LFSR into a hit or miss, a damage value and an ammo update. It sits between the collision detector and key decoder on the input side and the HUD/VGA overlay on the output side.

## Interface
Parameters:
- `HP_W`, 8: width of HP and damage values.
- `ATK_N`, 4: number of attack types; ids run 0..ATK_N-1.
- `FREE_N`, 2: ids below `FREE_N` have unlimited use.
- `AMMO_W`, 5: width of each ammo counter.
- `AMMO_INIT`, 3: ammo loaded per limited attack, per side, on `start`.
- `PLAYER_HP_MAX`, 100: player starting HP.
- `ENEMY_HP_MIN`, 50: lowest possible enemy starting HP.
- `BASE_STEP`, 10: base damage per attack tier.
- `MISS_STEP`, 3: accuracy penalty per attack tier.
- `LFSR_SEED`, 16'hACE1: LFSR value after reset; must be nonzero.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: one-cycle pulse that begins or restarts a battle.
- `act_valid`, in, 1: an action is offered.
- `act_id`, in, `$clog2(ATK_N)`: attack type of the offered action.
- `act_ready`, out, 1: engine can accept an action.
- `turn`, out, 1: 0 = player's turn, 1 = enemy's turn.
- `busy`, out, 1: high in every state except IDLE and DONE.
- `player_hp`, out, `HP_W`: player HP.
- `enemy_hp`, out, `HP_W`: enemy HP.
- `player_ammo`, out, `ATK_N*AMMO_W`: player ammo counters; slice i belongs to id i.
- `enemy_ammo`, out, `ATK_N*AMMO_W`: enemy ammo counters; slice i belongs to id i.
- `res_valid`, out, 1: one-cycle pulse marking a resolved action.
- `res_hit`, out, 1: resolved action hit.
- `res_empty`, out, 1: resolved action had no ammo.
- `res_crit`, out, 1: resolved action was a critical hit.
- `res_dmg`, out, `HP_W`: damage actually applied.
- `player_win`, out, 1: player has won.
- `enemy_win`, out, 1: enemy has won.

## Operation
States: IDLE, P_WAIT, E_WAIT, RESOLVE, DONE.

Reset:
- State goes to IDLE and the LFSR loads `LFSR_SEED`.
- Both HP outputs are 0, all ammo slices are 0, and all `res_*` and win outputs are 0.
- `turn` is 0 and `act_ready` is 0.

`start`, accepted in any state:
- `player_hp` = `PLAYER_HP_MAX`.
- `enemy_hp` = `ENEMY_HP_MIN` + (lfsr[7:0] mod (`PLAYER_HP_MAX` - `ENEMY_HP_MIN` + 1)).
- Ammo slices for ids ≥ `FREE_N` = `AMMO_INIT`; slices for ids < `FREE_N` = 0, and are never read.
- Win flags clear, and the state goes to P_WAIT.

Wait states:
- `act_ready` = 1 only in P_WAIT and E_WAIT.
- A handshake completes when `act_valid` and `act_ready` are both high. The engine latches `act_id` and the attacker side, then goes to RESOLVE.
- `act_id` ≥ `ATK_N` is treated as id 0.

RESOLVE, for id k, using a single LFSR snapshot:
- Empty: k ≥ `FREE_N` and the attacker's ammo[k] == 0. Result is `res_empty` = 1, `res_dmg` = 0, no ammo change.
- Hit test: lfsr[15:12] ≥ `MISS_STEP`*k. Id 0 always hits.
- Damage = `BASE_STEP`*(k+1) - (k+1) + (lfsr[7:0] mod (2k+3)), so the range is base ± (k+1).
- A miss applies 0 damage. Limited ammo decrements on both hit and miss.
- Defender HP saturates at 0: if HP < damage, HP becomes 0, and `res_dmg` reports the HP actually removed.
- Next state:
  - DONE if the defender's HP is 0; the attacker's win flag sets and is held until `start` or `rst`.
  - Otherwise the other side's wait state: player → E_WAIT, enemy → P_WAIT.

Other rules:
- The LFSR advances every cycle: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
- `start` in the same cycle as a handshake: `start` wins and the action is discarded.
- `rst` overrides everything.
- `act_valid` in IDLE, RESOLVE or DONE is ignored.

## Timing
- Handshake in cycle T, RESOLVE in T+1. HP, ammo and the `res_*` outputs are registered and visible in T+2, with `res_valid` high for exactly 1 cycle.
- The next wait state, with `act_ready` = 1, is entered in T+2. Minimum action spacing is therefore 2 cycles.
- `start` in cycle T: initial values and P_WAIT are visible in T+1.
- The `res_*` data outputs hold their values between pulses.

## Configuration
- `BATTLE_CRIT_EN` defined:
  - A hit with lfsr[3:0] == 0 is critical; damage doubles, saturating at 2^`HP_W`-1, before the HP clamp.
  - `res_crit` pulses together with `res_valid`.
- `BATTLE_CRIT_EN` undefined: there is no doubling logic and `res_crit` is tied to 0.

## Structure
- Package `battle_pkg` holds:
  - the state enum `battle_state_t`;
  - the side enum (`SIDE_PLAYER`, `SIDE_ENEMY`);
  - the LFSR polynomial and width constants.
- Sub-module `battle_lfsr`: holds the 16-bit Galois LFSR. Takes `clk`, `rst` and `seed`; outputs `q`.
- Per-id damage and accuracy logic is generated with a generate loop over `ATK_N`.

## Test plan
- Reset then `start`, default parameters:
  - `player_hp` = 100 and `enemy_hp` is in 50..100;
  - ammo for ids 2 and 3 = 3 on both sides; `turn` = 0 and `act_ready` = 1.
- Player id 0, then enemy id 0:
  - each `res_valid` arrives 2 cycles after its handshake, with `res_hit` = 1 and `res_dmg` in 9..11;
  - `turn` toggles 0 → 1 → 0.
- Player fires id 3 four times, enemy uses id 0 in between:
  - player ammo[3] reads 2, 1, 0;
  - the 4th attempt gives `res_empty` = 1 and `res_dmg` = 0, and enemy HP is unchanged.
- Repeated player id 1 until `enemy_hp` reaches 0:
  - the final hit reports `res_dmg` equal to the remaining HP;
  - then `player_win` = 1, DONE, `act_ready` = 0, and later `act_valid` is ignored.
- `start` asserted in the same cycle as a handshake during E_WAIT:
  - the action is discarded and HP is re-initialised;
  - P_WAIT is entered in the next cycle and no `res_valid` pulse occurs.
- `rst` asserted during RESOLVE: the next cycle shows IDLE, HP = 0 and no `res_valid` pulse.
- With `BATTLE_CRIT_EN` defined, force the seed so that a hit has lfsr[3:0] == 0:
  - `res_crit` = 1 and `res_dmg` equals double the normal damage (clamped).

Source files
------------

// File: rtl/battle_pkg.sv
// Shared types and LFSR constants for the battle engine.
package battle_pkg;

  localparam int unsigned LFSR_W = 16;
  // Right-shift Galois taps for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    P_WAIT,
    E_WAIT,
    RESOLVE,
    DONE
  } battle_state_t;

  typedef enum logic {
    SIDE_PLAYER = 1'b0,
    SIDE_ENEMY  = 1'b1
  } side_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : '0);
  endfunction

endpackage

// File: rtl/battle_engine_if.sv
// Action channel, status and result bus between the battle engine and its neighbours.
interface battle_engine_if #(
  parameter int unsigned HP_W   = 8,
  parameter int unsigned ATK_N  = 4,
  parameter int unsigned AMMO_W = 5
);
  localparam int unsigned ID_W = (ATK_N > 1) ? $clog2(ATK_N) : 1;

  logic                     start;
  logic                     act_valid;
  logic [ID_W-1:0]          act_id;
  logic                     act_ready;
  logic                     turn;
  logic                     busy;
  logic [HP_W-1:0]          player_hp;
  logic [HP_W-1:0]          enemy_hp;
  logic [ATK_N*AMMO_W-1:0]  player_ammo;
  logic [ATK_N*AMMO_W-1:0]  enemy_ammo;
  logic                     res_valid;
  logic                     res_hit;
  logic                     res_empty;
  logic                     res_crit;
  logic [HP_W-1:0]          res_dmg;
  logic                     player_win;
  logic                     enemy_win;

  modport master (
    output start, act_valid, act_id,
    input  act_ready, turn, busy, player_hp, enemy_hp, player_ammo, enemy_ammo,
    input  res_valid, res_hit, res_empty, res_crit, res_dmg, player_win, enemy_win
  );

  modport slave (
    input  start, act_valid, act_id,
    output act_ready, turn, busy, player_hp, enemy_hp, player_ammo, enemy_ammo,
    output res_valid, res_hit, res_empty, res_crit, res_dmg, player_win, enemy_win
  );
endinterface

// File: rtl/battle_lfsr.sv
// Free-running 16-bit Galois LFSR, reloaded with the seed on reset.
module battle_lfsr
  import battle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= seed;
    else     lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;
endmodule

// File: rtl/battle_engine.sv
// Turn-based battle resolver: alternating player/enemy actions resolved against an LFSR.
// Optional critical hits are enabled by defining BATTLE_CRIT_EN.
module battle_engine
  import battle_pkg::*;
#(
  parameter int unsigned       HP_W          = 8,
  parameter int unsigned       ATK_N         = 4,
  parameter int unsigned       FREE_N        = 2,
  parameter int unsigned       AMMO_W        = 5,
  parameter int unsigned       AMMO_INIT     = 3,
  parameter int unsigned       PLAYER_HP_MAX = 100,
  parameter int unsigned       ENEMY_HP_MIN  = 50,
  parameter int unsigned       BASE_STEP     = 10,
  parameter int unsigned       MISS_STEP     = 3,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1
) (
  input logic             clk,
  input logic             rst,
  battle_engine_if.slave  bus
);
  localparam int unsigned ID_W    = (ATK_N > 1) ? $clog2(ATK_N) : 1;
  localparam int unsigned HP_SPAN = PLAYER_HP_MAX - ENEMY_HP_MIN + 1;

  typedef logic [ATK_N-1:0][AMMO_W-1:0] ammo_t;

  logic [LFSR_W-1:0] lfsr;
  logic              unused_lfsr;

  battle_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr)
  );

  assign unused_lfsr = ^lfsr[11:8];

  // Per-attack accuracy, damage and reload value, all from the current LFSR value
  logic [ATK_N-1:0] hit_ok;
  logic [HP_W-1:0]  dmg_tab [ATK_N];
  ammo_t            ammo_init;

  for (genvar k = 0; k < ATK_N; k++) begin : g_atk
    localparam int unsigned TIER = k + 1;
    assign hit_ok[k]    = 32'(lfsr[15:12]) >= MISS_STEP * TIER - MISS_STEP;
    assign dmg_tab[k]   = HP_W'(BASE_STEP * TIER - TIER + (32'(lfsr[7:0]) % (2 * TIER + 1)));
    assign ammo_init[k] = (TIER > FREE_N) ? AMMO_W'(AMMO_INIT) : '0;
  end

  battle_state_t   state_q, state_d;
  side_t           side_q, side_d;
  logic [ID_W-1:0] id_q, id_d, id_in;
  logic            turn_q, turn_d, ready_q, ready_d, busy_q, busy_d;
  logic [HP_W-1:0] php_q, php_d, ehp_q, ehp_d;
  ammo_t           pammo_q, pammo_d, eammo_q, eammo_d;
  logic            res_valid_q, res_valid_d, res_hit_q, res_hit_d;
  logic            res_empty_q, res_empty_d, res_crit_q, res_crit_d;
  logic [HP_W-1:0] res_dmg_q, res_dmg_d;
  logic            pwin_q, pwin_d, ewin_q, ewin_d;

  logic              limited, empty, hit, crit;
  logic [AMMO_W-1:0] att_ammo;
  logic [HP_W-1:0]   raw_dmg, def_hp, applied;

  assign id_in = (32'(bus.act_id) < ATK_N) ? bus.act_id : '0;

  // Outcome of the latched action against this cycle's LFSR snapshot
  always_comb begin
    limited  = 32'(id_q) >= FREE_N;
    att_ammo = (side_q == SIDE_PLAYER) ? pammo_q[id_q] : eammo_q[id_q];
    empty    = limited && (att_ammo == '0);
    hit      = !empty && hit_ok[id_q];
    raw_dmg  = hit ? dmg_tab[id_q] : '0;
    crit     = 1'b0;
`ifdef BATTLE_CRIT_EN
    crit     = hit && (lfsr[3:0] == 4'd0);
    if (crit) raw_dmg = raw_dmg[HP_W-1] ? '1 : (raw_dmg << 1);
`endif
    def_hp   = (side_q == SIDE_PLAYER) ? ehp_q : php_q;
    applied  = (def_hp < raw_dmg) ? def_hp : raw_dmg;
  end

  always_comb begin
    state_d     = state_q;
    side_d      = side_q;
    id_d        = id_q;
    turn_d      = turn_q;
    php_d       = php_q;
    ehp_d       = ehp_q;
    pammo_d     = pammo_q;
    eammo_d     = eammo_q;
    res_valid_d = 1'b0;
    res_hit_d   = res_hit_q;
    res_empty_d = res_empty_q;
    res_crit_d  = res_crit_q;
    res_dmg_d   = res_dmg_q;
    pwin_d      = pwin_q;
    ewin_d      = ewin_q;

    if (bus.start) begin
      state_d = P_WAIT;
      turn_d  = 1'b0;
      php_d   = HP_W'(PLAYER_HP_MAX);
      ehp_d   = HP_W'(ENEMY_HP_MIN + (32'(lfsr[7:0]) % HP_SPAN));
      pammo_d = ammo_init;
      eammo_d = ammo_init;
      pwin_d  = 1'b0;
      ewin_d  = 1'b0;
    end else begin
      unique case (state_q)
        P_WAIT, E_WAIT: begin
          if (bus.act_valid && ready_q) begin
            state_d = RESOLVE;
            id_d    = id_in;
            side_d  = (state_q == E_WAIT) ? SIDE_ENEMY : SIDE_PLAYER;
          end
        end
        RESOLVE: begin
          res_valid_d = 1'b1;
          res_hit_d   = hit;
          res_empty_d = empty;
          res_crit_d  = crit;
          res_dmg_d   = applied;
          // Limited ammo is spent on hit or miss, but not on an empty attempt
          if (limited && !empty) begin
            if (side_q == SIDE_PLAYER) pammo_d[id_q] = att_ammo - AMMO_W'(1);
            else                       eammo_d[id_q] = att_ammo - AMMO_W'(1);
          end
          if (side_q == SIDE_PLAYER) ehp_d = def_hp - applied;
          else                       php_d = def_hp - applied;
          if (def_hp == applied) begin
            state_d = DONE;
            if (side_q == SIDE_PLAYER) pwin_d = 1'b1;
            else                       ewin_d = 1'b1;
          end else begin
            state_d = (side_q == SIDE_PLAYER) ? E_WAIT : P_WAIT;
            turn_d  = (side_q == SIDE_PLAYER);
          end
        end
        default: ;
      endcase
    end

    ready_d = (state_d == P_WAIT) || (state_d == E_WAIT);
    busy_d  = (state_d != IDLE) && (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      side_q      <= SIDE_PLAYER;
      id_q        <= '0;
      turn_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      php_q       <= '0;
      ehp_q       <= '0;
      pammo_q     <= '0;
      eammo_q     <= '0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_empty_q <= 1'b0;
      res_crit_q  <= 1'b0;
      res_dmg_q   <= '0;
      pwin_q      <= 1'b0;
      ewin_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      side_q      <= side_d;
      id_q        <= id_d;
      turn_q      <= turn_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      php_q       <= php_d;
      ehp_q       <= ehp_d;
      pammo_q     <= pammo_d;
      eammo_q     <= eammo_d;
      res_valid_q <= res_valid_d;
      res_hit_q   <= res_hit_d;
      res_empty_q <= res_empty_d;
      res_crit_q  <= res_crit_d;
      res_dmg_q   <= res_dmg_d;
      pwin_q      <= pwin_d;
      ewin_q      <= ewin_d;
    end
  end

  assign bus.act_ready   = ready_q;
  assign bus.turn        = turn_q;
  assign bus.busy        = busy_q;
  assign bus.player_hp   = php_q;
  assign bus.enemy_hp    = ehp_q;
  assign bus.player_ammo = pammo_q;
  assign bus.enemy_ammo  = eammo_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_hit     = res_hit_q;
  assign bus.res_empty   = res_empty_q;
  assign bus.res_crit    = res_crit_q;
  assign bus.res_dmg     = res_dmg_q;
  assign bus.player_win  = pwin_q;
  assign bus.enemy_win   = ewin_q;
endmodule
